// File: rtl/memory_writer.sv
// memory_writer: row-major frame store into a single-port result BRAM.
// Accepts one pixel per clock from the processing pipeline, registers it
// once, and drives the BRAM write port. It also pulses line/frame completion
// and flags pixels that arrive when they cannot be stored.
module memory_writer #(
    parameter int MAX_ROW = 540,
    parameter int MAX_COL = 540
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        ena_o,
    output logic        wea_o,
    output logic [18:0] addr_o,
    output logic [7:0]  d2mem_o,
    input  logic [7:0]  mem2d_i,
    input  logic [7:0]  data_i,
    input  logic        data_en_i,
    input  logic        store_run_i,
    output logic        store_done_o,
    output logic        line_done_o,
    output logic        err_drop_o,
    output logic [9:0]  cnt_img_row_o,
    output logic [9:0]  cnt_img_col_o
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WRITE = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [9:0] ROW_LAST = 10'(MAX_ROW - 1);
    localparam logic [9:0] COL_LAST = 10'(MAX_COL - 1);

    logic [1:0]  r_state;
    logic [18:0] r_addr;
    logic [9:0]  r_row;
    logic [9:0]  r_col;
    logic        r_wr_vld;
    logic [18:0] r_wr_addr;
    logic [7:0]  r_wr_data;
    logic        r_wr_line;
    logic        r_wr_last;
    logic        r_store_done;
    logic        r_err_drop;

    logic w_accept;
    logic w_last;
    logic w_unused;

    // Read data is never used; this block only writes.
    assign w_unused = ^mem2d_i;

    assign w_accept = (r_state == WRITE) && store_run_i && data_en_i;
    assign w_last   = (r_row == ROW_LAST) && (r_col == COL_LAST);

    // Frame FSM: run gates WRITE; the last pixel parks one cycle in DONE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE:    if (store_run_i) r_state <= WRITE;
                WRITE: begin
                    if (!store_run_i)           r_state <= IDLE;
                    else if (w_accept && w_last) r_state <= DONE;
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Position counters; they hold on pause and clear on the frame's last pixel.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_addr <= '0;
            r_row  <= '0;
            r_col  <= '0;
        end else if (w_accept) begin
            if (w_last) begin
                r_addr <= '0;
                r_row  <= '0;
                r_col  <= '0;
            end else begin
                r_addr <= r_addr + 19'd1;
                if (r_col == COL_LAST) begin
                    r_col <= '0;
                    r_row <= r_row + 10'd1;
                end else begin
                    r_col <= r_col + 10'd1;
                end
            end
        end
    end

    // Write register stage; address/data are zeroed when no write is pending.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_vld     <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_wr_line    <= 1'b0;
            r_wr_last    <= 1'b0;
            r_store_done <= 1'b0;
        end else begin
            r_wr_vld     <= w_accept;
            r_wr_addr    <= w_accept ? r_addr : '0;
            r_wr_data    <= w_accept ? data_i : '0;
            r_wr_line    <= w_accept && (r_col == COL_LAST);
            r_wr_last    <= w_accept && w_last;
            r_store_done <= r_wr_last;
        end
    end

    // Sticky drop flag: any valid pixel that was not accepted.
    always_ff @(posedge clk) begin
        if (!rst_n)                      r_err_drop <= 1'b0;
        else if (data_en_i && !w_accept) r_err_drop <= 1'b1;
    end

    assign ena_o         = r_wr_vld;
    assign wea_o         = r_wr_vld;
    assign addr_o        = r_wr_addr;
    assign d2mem_o       = r_wr_data;
    assign line_done_o   = r_wr_line;
    assign store_done_o  = r_store_done;
    assign err_drop_o    = r_err_drop;
    assign cnt_img_row_o = r_row;
    assign cnt_img_col_o = r_col;

endmodule

// File: tb/tb_memory_writer.sv
// Directed bench for memory_writer with a 4x5 frame.
module tb_memory_writer;
    localparam int R = 4;
    localparam int C = 5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena_o, wea_o, store_done_o, line_done_o, err_drop_o;
    logic [18:0] addr_o;
    logic [7:0]  d2mem_o, mem2d_i, data_i;
    logic        data_en_i, store_run_i;
    logic [9:0]  cnt_img_row_o, cnt_img_col_o;

    int checks   = 0;
    int failures = 0;
    int exp_addr = 0;

    memory_writer #(.MAX_ROW(R), .MAX_COL(C)) dut (
        .clk(clk), .rst_n(rst_n), .ena_o(ena_o), .wea_o(wea_o),
        .addr_o(addr_o), .d2mem_o(d2mem_o), .mem2d_i(mem2d_i),
        .data_i(data_i), .data_en_i(data_en_i), .store_run_i(store_run_i),
        .store_done_o(store_done_o), .line_done_o(line_done_o),
        .err_drop_o(err_drop_o), .cnt_img_row_o(cnt_img_row_o),
        .cnt_img_col_o(cnt_img_col_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ena"},  32'(ena_o), 0);
        chk({tag, "_wea"},  32'(wea_o), 0);
        chk({tag, "_addr"}, 32'(addr_o), 0);
        chk({tag, "_data"}, 32'(d2mem_o), 0);
        chk({tag, "_sdone"}, 32'(store_done_o), 0);
        chk({tag, "_line"}, 32'(line_done_o), 0);
        chk({tag, "_err"},  32'(err_drop_o), 0);
        chk({tag, "_row"},  32'(cnt_img_row_o), 0);
        chk({tag, "_col"},  32'(cnt_img_col_o), 0);
    endtask

    // One accepted pixel: it must appear on the BRAM port after the edge.
    task automatic px(input logic [7:0] d);
        data_i    = d;
        data_en_i = 1'b1;
        tick();
        chk("px_ena",  32'(ena_o), 1);
        chk("px_wea",  32'(wea_o), 1);
        chk("px_addr", 32'(addr_o), 32'(exp_addr));
        chk("px_data", 32'(d2mem_o), 32'(d));
        chk("px_line", 32'(line_done_o), 32'((exp_addr % C) == C - 1));
        chk("px_sdone", 32'(store_done_o), 0);
        exp_addr  = (exp_addr + 1) % (R * C);
        data_en_i = 1'b0;
        data_i    = 8'h00;
    endtask

    task automatic gap();
        data_en_i = 1'b0;
        tick();
        chk("gap_ena",  32'(ena_o), 0);
        chk("gap_addr", 32'(addr_o), 0);
    endtask

    // The two cycles after the last pixel: DONE (optionally with a drop), then IDLE.
    task automatic frame_end(input logic drop_in_done);
        data_en_i = drop_in_done;
        data_i    = 8'hAA;
        tick();
        data_en_i = 1'b0;
        chk("end_sdone", 32'(store_done_o), 1);
        chk("end_ena",   32'(ena_o), 0);
        chk("end_data",  32'(d2mem_o), 0);
        tick();
        chk("end_sdone_off", 32'(store_done_o), 0);
        chk("end_ena2",      32'(ena_o), 0);
        chk("end_row", 32'(cnt_img_row_o), 0);
        chk("end_col", 32'(cnt_img_col_o), 0);
    endtask

    task automatic frame(input logic [7:0] base);
        for (int i = 0; i < R * C; i++) px(8'(i) ^ base);
        frame_end(1'b0);
    endtask

    initial begin
        logic [19:0] gap_mask;
        gap_mask    = 20'b0000_1000_1100_0010_1100; // gap before pixels 2,3,5,10,11,15
        rst_n       = 1'b0;
        store_run_i = 1'b0;
        data_en_i   = 1'b0;
        data_i      = 8'h00;
        mem2d_i     = 8'h00;

        // Reset with random inputs.
        for (int i = 0; i < 3; i++) begin
            store_run_i = 1'($urandom);
            data_en_i   = 1'($urandom);
            data_i      = 8'($urandom);
            mem2d_i     = 8'($urandom);
            tick();
            chk_all_zero("rst");
        end
        store_run_i = 1'b0;
        data_en_i   = 1'b0;
        rst_n       = 1'b1;
        gap();
        gap();
        chk("post_rst_err", 32'(err_drop_o), 0);

        // Full frame, data = index.
        store_run_i = 1'b1;
        gap();
        frame(8'h00);
        chk("full_err", 32'(err_drop_o), 0);

        // Gapped stream with a 3-cycle pause after pixel 7.
        for (int i = 0; i < R * C; i++) begin
            if (gap_mask[i]) gap();
            px(8'(i) ^ 8'h5A);
            if (i == 7) begin
                store_run_i = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    gap();
                    chk("pause_row", 32'(cnt_img_row_o), 1);
                    chk("pause_col", 32'(cnt_img_col_o), 3);
                end
                store_run_i = 1'b1;
                gap();
            end
        end
        frame_end(1'b0);
        chk("gapped_err", 32'(err_drop_o), 0);

        // Drop while IDLE.
        store_run_i = 1'b0;
        data_en_i   = 1'b1;
        data_i      = 8'h33;
        tick();
        data_en_i   = 1'b0;
        chk("drop_idle_ena", 32'(ena_o), 0);
        chk("drop_idle_err", 32'(err_drop_o), 1);
        chk("drop_idle_col", 32'(cnt_img_col_o), 0);

        // Drop in the DONE cycle, then consecutive frames from address 0.
        store_run_i = 1'b1;
        gap();
        for (int i = 0; i < R * C; i++) px(8'(i) ^ 8'hC3);
        frame_end(1'b1);
        chk("drop_done_err", 32'(err_drop_o), 1);
        frame(8'h11);
        frame(8'h80);
        chk("consec_err", 32'(err_drop_o), 1);

        // Mid-frame reset after pixel 12.
        for (int i = 0; i <= 12; i++) px(8'(i) ^ 8'h0F);
        chk("mid_row", 32'(cnt_img_row_o), 2);
        chk("mid_col", 32'(cnt_img_col_o), 3);
        rst_n     = 1'b0;
        data_en_i = 1'b1;
        data_i    = 8'h77;
        tick();
        data_en_i = 1'b0;
        chk_all_zero("midrst");
        rst_n    = 1'b1;
        exp_addr = 0;
        gap();
        for (int i = 0; i < 3; i++) px(8'(i) ^ 8'hF0);
        chk("after_rst_err", 32'(err_drop_o), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
